// File: rtl/fe_prefetch_writer.sv
// fe_prefetch_writer: write side of the 4 x 128-bit rotating prefetch buffer.
// Requests 16-byte aligned lines from the icache and writes them round-robin
// into slots 0-3. Also owns the byte read pointer and valid-byte count used by
// the fetch shifter, and flushes/refetches on an EIP redirect.
//
// Ports:
//   clk, reset (async, active-low)
//   load_eip, eip_target, cs_limit          redirect and segment limit
//   icache_ready, icache_data               icache response
//   consume, consume_len                    decoder retirement
//   icache_en, icache_address               icache request
//   buf_0..buf_3                            slot contents
//   read_ptr, byte_count, instr_valid       shifter view of the ring
//   segment_limit_exception                 sticky fetch fault
module fe_prefetch_writer #(
  parameter logic [31:0] RESET_EIP = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_eip,
  input  logic [31:0]  eip_target,
  input  logic [31:0]  cs_limit,
  input  logic         icache_ready,
  input  logic [127:0] icache_data,
  input  logic         consume,
  input  logic [3:0]   consume_len,
  output logic         icache_en,
  output logic [31:0]  icache_address,
  output logic [127:0] buf_0,
  output logic [127:0] buf_1,
  output logic [127:0] buf_2,
  output logic [127:0] buf_3,
  output logic [5:0]   read_ptr,
  output logic [6:0]   byte_count,
  output logic         instr_valid,
  output logic         segment_limit_exception
);

  localparam int unsigned LINE_W  = 128;
  localparam int unsigned NSLOTS  = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned USED_W  = 3;
  localparam int unsigned PTR_W   = 6;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned LADDR_W = 28;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t               state, state_d;
  logic [LADDR_W-1:0]   fetch_addr;
  logic [IDX_W-1:0]     wr_idx;
  logic [USED_W-1:0]    lines_used;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 first_line;
  logic                 fault;
  logic [LINE_W-1:0]    slot_q [NSLOTS];

  // Control strobes derived from the current registered state
  logic                 limit_ok;
  logic                 line_wr;
  logic                 cons_ok;
  logic                 slot_free;
  logic                 fault_set;
  logic [CNT_W-1:0]     add_bytes;
  logic [CNT_W-1:0]     sub_bytes;
  logic [4:0]           ptr_sum;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state and per-cycle strobes
  always_comb begin
    state_d   = state;
    limit_ok  = ({fetch_addr, 4'h0} <= cs_limit);
    line_wr   = 1'b0;
    cons_ok   = 1'b0;
    slot_free = 1'b0;
    fault_set = 1'b0;
    add_bytes = '0;
    sub_bytes = '0;
    ptr_sum   = {1'b0, rd_ptr_q[3:0]} + {1'b0, consume_len};

    if (load_eip) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (!limit_ok)
            fault_set = 1'b1;
          else if ((lines_used < 3'd4) && !fault)
            state_d = REQ;
        end
        REQ: begin
          if (icache_ready) begin
            line_wr = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      cons_ok   = consume && instr_valid && (consume_len != 4'd0);
      // Crossing a 16-byte boundary releases the slot just read past
      slot_free = cons_ok && ptr_sum[4];
    end

    // First line after a redirect only counts bytes at or after the target
    if (line_wr)
      add_bytes = first_line ? 7'(5'd16 - {1'b0, rd_ptr_q[3:0]}) : 7'd16;
    if (cons_ok)
      sub_bytes = 7'(consume_len);
  end

  // Fetch address, ring bookkeeping and fault
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_addr <= RESET_EIP[31:4];
      wr_idx     <= '0;
      lines_used <= '0;
      rd_ptr_q   <= {2'b00, RESET_EIP[3:0]};
      count_q    <= '0;
      first_line <= 1'b1;
      fault      <= 1'b0;
    end else if (load_eip) begin
      fetch_addr <= eip_target[31:4];
      wr_idx     <= '0;
      lines_used <= '0;
      rd_ptr_q   <= {2'b00, eip_target[3:0]};
      count_q    <= '0;
      first_line <= 1'b1;
      fault      <= 1'b0;
    end else begin
      if (line_wr) begin
        fetch_addr <= fetch_addr + 28'd1;
        wr_idx     <= wr_idx + 2'd1;
        first_line <= 1'b0;
      end
      lines_used <= lines_used + {2'b00, line_wr} - {2'b00, slot_free};
      count_q    <= count_q + add_bytes - sub_bytes;
      if (cons_ok)
        rd_ptr_q <= rd_ptr_q + {2'b00, consume_len};
      if (fault_set)
        fault <= 1'b1;
    end
  end

  // Slot storage; contents survive a redirect and are masked by byte_count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NSLOTS; i++) slot_q[i] <= '0;
    end else if (line_wr) begin
      slot_q[wr_idx] <= icache_data;
    end
  end

  assign icache_en               = (state == REQ);
  assign icache_address          = {fetch_addr, 4'h0};
  assign buf_0                   = slot_q[0];
  assign buf_1                   = slot_q[1];
  assign buf_2                   = slot_q[2];
  assign buf_3                   = slot_q[3];
  assign read_ptr                = rd_ptr_q;
  assign byte_count              = count_q;
  assign instr_valid             = (count_q >= 7'd16);
  assign segment_limit_exception = fault;

endmodule

// File: tb/tb_fe_prefetch_writer.sv
// Bench for fe_prefetch_writer. The reference model tracks absolute byte
// addresses: the read position, the end of fetched data and the redirect
// base line. Ring pointer, byte count and slot occupancy are derived from
// those with plain arithmetic.
module tb_fe_prefetch_writer;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_eip;
  logic [31:0]  eip_target;
  logic [31:0]  cs_limit;
  logic         icache_ready;
  logic [127:0] icache_data;
  logic         consume;
  logic [3:0]   consume_len;
  logic         icache_en;
  logic [31:0]  icache_address;
  logic [127:0] buf_0, buf_1, buf_2, buf_3;
  logic [5:0]   read_ptr;
  logic [6:0]   byte_count;
  logic         instr_valid;
  logic         segment_limit_exception;

  int total = 0;
  int bad   = 0;
  string phase = "reset";

  fe_prefetch_writer #(.RESET_EIP(32'h0000_0000)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .load_eip                (load_eip),
    .eip_target              (eip_target),
    .cs_limit                (cs_limit),
    .icache_ready            (icache_ready),
    .icache_data             (icache_data),
    .consume                 (consume),
    .consume_len             (consume_len),
    .icache_en               (icache_en),
    .icache_address          (icache_address),
    .buf_0                   (buf_0),
    .buf_1                   (buf_1),
    .buf_2                   (buf_2),
    .buf_3                   (buf_3),
    .read_ptr                (read_ptr),
    .byte_count              (byte_count),
    .instr_valid             (instr_valid),
    .segment_limit_exception (segment_limit_exception)
  );

  always #5 clk = ~clk;

  // Reference model state (absolute addresses)
  longint       m_base;   // line index of the redirect target
  longint       m_rd;     // byte address of the read position
  longint       m_next;   // line index of the next line to fetch
  bit           m_req;
  bit           m_fault;
  logic [127:0] m_ring [4];

  function automatic longint m_count();
    longint d = m_next * 16 - m_rd;
    return (d < 0) ? 0 : d;
  endfunction

  function automatic longint m_lines();
    return m_next - (m_rd / 16);
  endfunction

  task automatic model_reset(input logic [31:0] eip);
    m_base  = longint'(eip) / 16;
    m_rd    = longint'(eip);
    m_next  = m_base;
    m_req   = 1'b0;
    m_fault = 1'b0;
    for (int i = 0; i < 4; i++) m_ring[i] = '0;
  endtask

  task automatic model_step(input bit ld, input logic [31:0] tgt, input bit cons,
                            input logic [3:0] clen, input bit rdy,
                            input logic [127:0] data, input logic [31:0] limit);
    longint c;
    longint l;
    bit     was_req;
    if (ld) begin
      m_base  = longint'(tgt) / 16;
      m_rd    = longint'(tgt);
      m_next  = m_base;
      m_req   = 1'b0;
      m_fault = 1'b0;
    end else begin
      c       = m_count();
      l       = m_lines();
      was_req = m_req;
      if (was_req && rdy) begin
        m_ring[int'((m_next - m_base) % 4)] = data;
        m_next++;
        m_req = 1'b0;
      end
      if (cons && c >= 16 && clen != 4'd0) m_rd += longint'(clen);
      if (!was_req) begin
        if (m_next * 16 > longint'(limit)) m_fault = 1'b1;
        else if (l < 4 && !m_fault)        m_req   = 1'b1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, name, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("icache_en",   {127'b0, icache_en},   {127'b0, m_req});
    chk("icache_addr", {96'b0, icache_address}, {96'b0, 32'(m_next * 16)});
    chk("read_ptr",    {122'b0, read_ptr},    {122'b0, 6'((m_rd - m_base * 16) % 64)});
    chk("byte_count",  {121'b0, byte_count},  {121'b0, 7'(m_count())});
    chk("instr_valid", {127'b0, instr_valid}, {127'b0, (m_count() >= 16)});
    chk("seg_exc",     {127'b0, segment_limit_exception}, {127'b0, m_fault});
    chk("buf_0", buf_0, m_ring[0]);
    chk("buf_1", buf_1, m_ring[1]);
    chk("buf_2", buf_2, m_ring[2]);
    chk("buf_3", buf_3, m_ring[3]);
  endtask

  // One cycle: drive after the falling edge, model at the rising edge, check at the next falling edge
  task automatic tick(input bit ld, input logic [31:0] tgt, input bit cons,
                      input logic [3:0] clen, input bit rdy);
    logic [127:0] d;
    bit           r;
    d = {$urandom, $urandom, $urandom, $urandom};
    r = rdy && icache_en;
    load_eip     = ld;
    eip_target   = tgt;
    consume      = cons;
    consume_len  = clen;
    icache_ready = r;
    icache_data  = d;
    @(posedge clk);
    model_step(ld, tgt, cons, clen, r, d, cs_limit);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_ticks(input int n, input bit rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 1'b0, 4'd0, rdy);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tgt;
    bit          seen;

    reset = 1'b0; load_eip = 1'b0; eip_target = '0; cs_limit = 32'hFFFF_FFFF;
    icache_ready = 1'b0; icache_data = '0; consume = 1'b0; consume_len = '0;
    model_reset(32'h0000_0000);
    #1;
    check_all();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Four lines fill the ring, then no further request
    phase = "fill";
    idle_ticks(12, 1'b1);
    chk("fill_count", {121'b0, byte_count}, 128'd64);
    chk("fill_rptr",  {122'b0, read_ptr},   128'd0);
    chk("fill_en",    {127'b0, icache_en},  128'd0);

    phase = "consume5";
    tick(1'b0, 32'h0, 1'b1, 4'd5, 1'b1);
    chk("c5_rptr",  {122'b0, read_ptr},   128'd5);
    chk("c5_count", {121'b0, byte_count}, 128'd59);
    idle_ticks(3, 1'b1);
    chk("c5_noreq", {127'b0, icache_en},  128'd0);

    // Crossing a line boundary frees slot 0, which line 0x40 then refills
    phase = "consume12";
    tick(1'b0, 32'h0, 1'b1, 4'd12, 1'b0);
    chk("c12_rptr", {122'b0, read_ptr}, 128'd17);
    tick(1'b0, 32'h0, 1'b0, 4'd0, 1'b0);
    chk("c12_addr", {96'b0, icache_address}, 128'h40);
    tick(1'b0, 32'h0, 1'b0, 4'd0, 1'b1);
    chk("c12_count", {121'b0, byte_count}, 128'd63);
    idle_ticks(3, 1'b1);

    phase = "redirect";
    tick(1'b1, 32'h1234_5677, 1'b0, 4'd0, 1'b0);
    chk("rd_en0",   {127'b0, icache_en},  128'd0);
    chk("rd_rptr",  {122'b0, read_ptr},   128'd7);
    tick(1'b0, 32'h0, 1'b0, 4'd0, 1'b0);
    chk("rd_addr",  {96'b0, icache_address}, 128'h1234_5670);
    tick(1'b0, 32'h0, 1'b0, 4'd0, 1'b1);
    chk("rd_cnt1",  {121'b0, byte_count},  128'd9);
    chk("rd_ivld1", {127'b0, instr_valid}, 128'd0);
    idle_ticks(2, 1'b1);
    chk("rd_cnt2",  {121'b0, byte_count},  128'd25);
    chk("rd_ivld2", {127'b0, instr_valid}, 128'd1);

    // Redirect coinciding with a response: data dropped, new target requested
    phase = "redirect_ready";
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (icache_en) seen = 1'b1;
      else tick(1'b0, 32'h0, 1'b0, 4'd0, 1'b0);
    end
    chk("rr_pending", {127'b0, icache_en}, 128'd1);
    tick(1'b1, 32'h0000_0100, 1'b0, 4'd0, 1'b1);
    chk("rr_count", {121'b0, byte_count}, 128'd0);
    tick(1'b0, 32'h0, 1'b0, 4'd0, 1'b0);
    chk("rr_addr",  {96'b0, icache_address}, 128'h100);
    idle_ticks(4, 1'b1);

    // Segment limit from a fresh reset
    phase = "limit";
    load_eip = 1'b0; consume = 1'b0; icache_ready = 1'b0;
    reset = 1'b0;
    cs_limit = 32'h0000_002F;
    #1;
    model_reset(32'h0000_0000);
    check_all();
    @(negedge clk);
    reset = 1'b1;
    idle_ticks(12, 1'b1);
    chk("lim_exc",   {127'b0, segment_limit_exception}, 128'd1);
    chk("lim_count", {121'b0, byte_count}, 128'd48);
    chk("lim_en",    {127'b0, icache_en},  128'd0);
    tick(1'b1, 32'h0, 1'b0, 4'd0, 1'b0);
    chk("lim_clear", {127'b0, segment_limit_exception}, 128'd0);
    idle_ticks(10, 1'b1);

    // Line write and boundary-crossing consume in the same cycle
    phase = "net_zero";
    cs_limit = 32'hFFFF_FFFF;
    tick(1'b1, 32'h0, 1'b0, 4'd0, 1'b0);
    idle_ticks(5, 1'b1);
    tick(1'b0, 32'h0, 1'b1, 4'd4, 1'b0);
    chk("nz_pend",  {127'b0, icache_en},  128'd1);
    chk("nz_cnt0",  {121'b0, byte_count}, 128'd28);
    tick(1'b0, 32'h0, 1'b1, 4'd12, 1'b1);
    chk("nz_cnt1",  {121'b0, byte_count}, 128'd32);
    chk("nz_rptr",  {122'b0, read_ptr},   128'd16);
    idle_ticks(8, 1'b1);
    chk("nz_full",  {121'b0, byte_count}, 128'd64);

    // Random traffic against the model
    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        tgt = $urandom_range(0, 32'h0FFF_FFFF);
        case ($urandom_range(0, 7))
          0:       cs_limit = (tgt > 32'd0) ? tgt - 32'd1 : 32'd0;
          1, 2:    cs_limit = tgt + $urandom_range(0, 32'h60);
          default: cs_limit = 32'hFFFF_FFFF;
        endcase
        tick(1'b1, tgt, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b1);
      end else begin
        tick(1'b0, 32'h0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             ($urandom_range(0, 2) != 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
